// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: sync strobes, visible flag, pixel coordinates and frame markers.
// The generator drives it through master; pixel stages observe it through slave.
interface vga_timing_gen_if;
   logic       hs;
   logic       vs;
   logic       blank;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       frame_start;
   logic [7:0] frame_count;

   modport master (output hs, vs, blank, DrawX, DrawY, frame_start, frame_count);
   modport slave  (input  hs, vs, blank, DrawX, DrawY, frame_start, frame_count);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Horizontal and vertical counters with registered sync, blank and frame markers.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic vga_clk,
   input  logic reset_n,
   vga_timing_gen_if.master vga
);

   localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [9:0] hc;
   logic [9:0] vc;
   logic [9:0] hc_next;
   logic [9:0] vc_next;
   logic       h_wrap;
   logic       v_wrap;
   logic       hs;
   logic       vs;
   logic       blank;
   logic       frame_start;
   logic [7:0] frame_count;

   always_comb begin
      h_wrap  = (hc == H_LAST);
      v_wrap  = (vc == V_LAST);
      hc_next = h_wrap ? 10'd0 : hc + 10'd1;
      vc_next = vc;
      if (h_wrap) begin
         vc_next = v_wrap ? 10'd0 : vc + 10'd1;
      end
   end

   // Strobes are decoded from the next-state counters so they line up with DrawX/DrawY.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hc          <= 10'd0;
         vc          <= 10'd0;
         hs          <= 1'b1;
         vs          <= 1'b1;
         blank       <= 1'b1;
         frame_start <= 1'b0;
         frame_count <= 8'd0;
      end else begin
         hc          <= hc_next;
         vc          <= vc_next;
         hs          <= !((hc_next >= HS_FIRST) && (hc_next <= HS_LAST));
         vs          <= !((vc_next >= VS_FIRST) && (vc_next <= VS_LAST));
         blank       <= (hc_next < H_VIS) && (vc_next < V_VIS);
         frame_start <= h_wrap && v_wrap;
         if (h_wrap && v_wrap) begin
            frame_count <= frame_count + 8'd1;
         end
      end
   end

   assign vga.DrawX       = hc;
   assign vga.DrawY       = vc;
   assign vga.hs          = hs;
   assign vga.vs          = vs;
   assign vga.blank       = blank;
   assign vga.frame_start = frame_start;
   assign vga.frame_count = frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a shrunken raster (15 x 10, 150 clocks per frame).
// Visible 8x6, hs low at x 10..12, vs low on lines 7..8.
module tb_vga_timing_gen;

   logic vga_clk;
   logic reset_n;
   int   n_vec;
   int   n_bad;
   int   cur;

   vga_timing_gen_if vif ();

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) dut (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .vga     (vif.master)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int cyc;
      int x;
      int y;
      int hs;
      int vs;
      int blank;
      int fs;
      int fc;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic advance_to(input int target);
      while (cur < target) begin
         @(negedge vga_clk);
         cur++;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".x"},     int'(vif.DrawX), 0);
      chk({tag, ".y"},     int'(vif.DrawY), 0);
      chk({tag, ".hs"},    int'(vif.hs), 1);
      chk({tag, ".vs"},    int'(vif.vs), 1);
      chk({tag, ".blank"}, int'(vif.blank), 1);
      chk({tag, ".fs"},    int'(vif.frame_start), 0);
      chk({tag, ".fc"},    int'(vif.frame_count), 0);
   endtask

   initial begin
      int fs_cnt, fs_off, fs_wide, hs_lo, vs_lo, blk_cnt, blk_bad, vs_chg_bad, pos_bad;
      int ex, ey, prev_fs, prev_vs;

      n_vec = 0;
      n_bad = 0;
      cur   = 0;

      //             cyc   x  y hs vs bl fs fc
      tbl[0]  = '{   1,  1, 0, 1, 1, 1, 0, 0};
      tbl[1]  = '{   7,  7, 0, 1, 1, 1, 0, 0};
      tbl[2]  = '{   8,  8, 0, 1, 1, 0, 0, 0};
      tbl[3]  = '{   9,  9, 0, 1, 1, 0, 0, 0};
      tbl[4]  = '{  10, 10, 0, 0, 1, 0, 0, 0};
      tbl[5]  = '{  12, 12, 0, 0, 1, 0, 0, 0};
      tbl[6]  = '{  13, 13, 0, 1, 1, 0, 0, 0};
      tbl[7]  = '{  14, 14, 0, 1, 1, 0, 0, 0};
      tbl[8]  = '{  15,  0, 1, 1, 1, 1, 0, 0};
      tbl[9]  = '{  89, 14, 5, 1, 1, 0, 0, 0};
      tbl[10] = '{  90,  0, 6, 1, 1, 0, 0, 0};
      tbl[11] = '{ 104, 14, 6, 1, 1, 0, 0, 0};
      tbl[12] = '{ 105,  0, 7, 1, 0, 0, 0, 0};
      tbl[13] = '{ 135,  0, 9, 1, 1, 0, 0, 0};
      tbl[14] = '{ 150,  0, 0, 1, 1, 1, 1, 1};
      tbl[15] = '{ 151,  1, 0, 1, 1, 1, 0, 1};

      reset_n = 1'b0;
      repeat (5) @(negedge vga_clk);
      chk_reset_vals("reset");

      reset_n = 1'b1;
      cur = 0;

      for (int i = 0; i < 16; i++) begin
         advance_to(tbl[i].cyc);
         chk($sformatf("vec%0d.x", i),     int'(vif.DrawX),       tbl[i].x);
         chk($sformatf("vec%0d.y", i),     int'(vif.DrawY),       tbl[i].y);
         chk($sformatf("vec%0d.hs", i),    int'(vif.hs),          tbl[i].hs);
         chk($sformatf("vec%0d.vs", i),    int'(vif.vs),          tbl[i].vs);
         chk($sformatf("vec%0d.blank", i), int'(vif.blank),       tbl[i].blank);
         chk($sformatf("vec%0d.fs", i),    int'(vif.frame_start), tbl[i].fs);
         chk($sformatf("vec%0d.fc", i),    int'(vif.frame_count), tbl[i].fc);
      end

      // Three full frames observed from (0,0) of frame 2.
      advance_to(300);
      chk("f2.origin", int'(vif.DrawX) + int'(vif.DrawY), 0);
      fs_cnt = 0; fs_off = 0; fs_wide = 0; hs_lo = 0; vs_lo = 0;
      blk_cnt = 0; blk_bad = 0; vs_chg_bad = 0; pos_bad = 0;
      ex = 0; ey = 0;
      prev_fs = int'(vif.frame_start);
      prev_vs = int'(vif.vs);
      for (int k = 0; k < 450; k++) begin
         advance_to(cur + 1);
         ex = (ex == 14) ? 0 : ex + 1;
         if (ex == 0) ey = (ey == 9) ? 0 : ey + 1;
         if (int'(vif.DrawX) != ex || int'(vif.DrawY) != ey) pos_bad++;
         if (vif.frame_start) begin
            fs_cnt++;
            if (vif.DrawX != 10'd0 || vif.DrawY != 10'd0) fs_off++;
            if (prev_fs == 1) fs_wide++;
         end
         if (!vif.hs) hs_lo++;
         if (!vif.vs) vs_lo++;
         if (vif.blank) blk_cnt++;
         if (vif.blank && vif.DrawY >= 10'd6) blk_bad++;
         if (int'(vif.vs) != prev_vs && vif.DrawX != 10'd0) vs_chg_bad++;
         prev_fs = int'(vif.frame_start);
         prev_vs = int'(vif.vs);
      end
      chk("run3.position_errors", pos_bad, 0);
      chk("run3.fs_pulses",       fs_cnt, 3);
      chk("run3.fs_off_origin",   fs_off, 0);
      chk("run3.fs_wider_than_1", fs_wide, 0);
      chk("run3.hs_low_clocks",   hs_lo, 90);
      chk("run3.vs_low_clocks",   vs_lo, 90);
      chk("run3.visible_clocks",  blk_cnt, 144);
      chk("run3.blank_in_vporch", blk_bad, 0);
      chk("run3.vs_change_x_ne0", vs_chg_bad, 0);
      chk("run3.frame_count",     int'(vif.frame_count), 5);

      // Run on to the 256th completed frame.
      fs_cnt = 0;
      while (cur < 38400) begin
         advance_to(cur + 1);
         if (vif.frame_start) fs_cnt++;
      end
      chk("wrap.fs_pulses",   fs_cnt, 251);
      chk("wrap.frame_count", int'(vif.frame_count), 0);
      chk("wrap.fs_now",      int'(vif.frame_start), 1);

      // Mid-frame reset at (11,7) of frame 257, where every output is off its reset value.
      advance_to(38666);
      chk("pre_rst.x",     int'(vif.DrawX), 11);
      chk("pre_rst.y",     int'(vif.DrawY), 7);
      chk("pre_rst.hs",    int'(vif.hs), 0);
      chk("pre_rst.vs",    int'(vif.vs), 0);
      chk("pre_rst.blank", int'(vif.blank), 0);
      chk("pre_rst.fc",    int'(vif.frame_count), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      repeat (3) @(negedge vga_clk);
      chk_reset_vals("held_rst");
      reset_n = 1'b1;
      cur = 0;
      fs_cnt = 0;
      while (cur < 149) begin
         advance_to(cur + 1);
         if (vif.frame_start) fs_cnt++;
      end
      chk("post_rst.fs_early", fs_cnt, 0);
      chk("post_rst.x149",     int'(vif.DrawX), 14);
      chk("post_rst.y149",     int'(vif.DrawY), 9);
      advance_to(150);
      chk("post_rst.fs",       int'(vif.frame_start), 1);
      chk("post_rst.x150",     int'(vif.DrawX), 0);
      chk("post_rst.y150",     int'(vif.DrawY), 0);
      chk("post_rst.fc",       int'(vif.frame_count), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
